// File: rtl/kbd_display_ctrl.sv
// kbd_display_ctrl
// Command sequencer between the PS/2 receiver and the character display and
// PWM datapath. Parses make, break (F0) and extended (E0) scancode sequences,
// keeps the requested glyph in a shadow register until the next frame
// boundary (vsync falling edge), and steps the PWM duty on arrow-key makes.
//
// Ports
//   clk            pixel-domain clock
//   reset          asynchronous, active-low reset
//   flag           one-cycle strobe, scancode valid in that cycle
//   scancode[7:0]  received byte
//   vsync          VGA vertical sync, active-low, synchronous to clk
//   start_address  committed glyph ROM base address
//   char_enable    committed glyph visible (1) or blanked (0)
//   duty[7:0]      PWM duty value
//   pending        a glyph update is latched and not yet committed
//   key_event      one-cycle pulse per accepted command
module kbd_display_ctrl #(
  parameter int unsigned CHAR_STRIDE = 8,
  parameter int unsigned DUTY_STEP   = 16,
  parameter int unsigned TIMEOUT_CYC = 1048575
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flag,
  input  logic [7:0] scancode,
  input  logic       vsync,
  output logic [5:0] start_address,
  output logic       char_enable,
  output logic [7:0] duty,
  output logic       pending,
  output logic       key_event
);

  localparam logic [7:0]  CODE_BREAK = 8'hF0;
  localparam logic [7:0]  CODE_EXT   = 8'hE0;
  localparam logic [7:0]  CODE_UP    = 8'h75;
  localparam logic [7:0]  CODE_DOWN  = 8'h72;
  localparam logic [19:0] TMO_LIMIT  = 20'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } state_t;

  state_t      state, state_next;
  logic [19:0] tmo_cnt;
  logic [7:0]  held_key;
  logic [2:0]  shadow_index;
  logic        shadow_blank;
  logic        vsync_d;

  logic        make_strobe, break_strobe, arrow_up, arrow_down;
  logic        timed_out;
  logic        key_valid, key_blank;
  logic [2:0]  key_index;
  logic        accept;
  logic        commit;
  logic [5:0]  commit_addr;
  logic [8:0]  duty_sum, duty_diff;

  // Make-code decoder: digit keys 1..8 select a glyph, Esc requests blank.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    key_valid = 1'b1;
    key_blank = 1'b0;
    key_index = 3'd0;
    case (scancode)
      8'h16:   key_index = 3'd0;
      8'h1E:   key_index = 3'd1;
      8'h26:   key_index = 3'd2;
      8'h25:   key_index = 3'd3;
      8'h2E:   key_index = 3'd4;
      8'h36:   key_index = 3'd5;
      8'h3D:   key_index = 3'd6;
      8'h3E:   key_index = 3'd7;
      8'h76:   key_blank = 1'b1;
      default: key_valid = 1'b0;
    endcase
  end

  assign timed_out = (state != ST_IDLE) && (tmo_cnt == TMO_LIMIT);

  // Prefix parser: transitions only on flag, except the idle-timeout escape.
  always_comb begin
    state_next   = state;
    make_strobe  = 1'b0;
    break_strobe = 1'b0;
    arrow_up     = 1'b0;
    arrow_down   = 1'b0;
    if (flag) begin
      case (state)
        ST_IDLE: begin
          if (scancode == CODE_BREAK)    state_next = ST_BRK;
          else if (scancode == CODE_EXT) state_next = ST_EXT;
          else                           make_strobe = 1'b1;
        end
        ST_BRK: begin
          state_next   = ST_IDLE;
          break_strobe = 1'b1;
        end
        ST_EXT: begin
          if (scancode == CODE_BREAK) begin
            state_next = ST_EXT_BRK;
          end else begin
            state_next = ST_IDLE;
            arrow_up   = (scancode == CODE_UP);
            arrow_down = (scancode == CODE_DOWN);
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (timed_out) begin
      state_next = ST_IDLE;
    end
  end

  // Typematic repeats of the held key are dropped; arrows are never dropped.
  assign accept = make_strobe && key_valid && (scancode != held_key);

  // Commit uses the shadow as it stood before this cycle, so a key accepted
  // on the edge cycle waits for the next frame.
  assign commit      = vsync_d && !vsync && pending;
  assign commit_addr = 6'(32'(shadow_index) * CHAR_STRIDE);

  // 9-bit arithmetic: bit 8 flags overflow (up) or borrow (down).
  assign duty_sum  = {1'b0, duty} + 9'(DUTY_STEP);
  assign duty_diff = {1'b0, duty} - 9'(DUTY_STEP);

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state <= ST_IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= state_next;
      if (flag || state == ST_IDLE || timed_out) tmo_cnt <= '0;
      else                                       tmo_cnt <= tmo_cnt + 20'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_key      <= 8'h00;
      shadow_index  <= 3'd0;
      shadow_blank  <= 1'b0;
      pending       <= 1'b0;
      vsync_d       <= 1'b1;
      start_address <= 6'd0;
      char_enable   <= 1'b0;
      duty          <= 8'h80;
      key_event     <= 1'b0;
    end else begin
      vsync_d   <= vsync;
      key_event <= accept || arrow_up || arrow_down;

      if (accept) held_key <= scancode;
      else if (break_strobe && scancode == held_key) held_key <= 8'h00;

      if (accept) begin
        shadow_index <= key_index;
        shadow_blank <= key_blank;
      end

      if (accept)      pending <= 1'b1;
      else if (commit) pending <= 1'b0;

      if (commit) begin
        if (shadow_blank) begin
          char_enable <= 1'b0;
        end else begin
          start_address <= commit_addr;
          char_enable   <= 1'b1;
        end
      end

      if (arrow_up)        duty <= duty_sum[8]  ? 8'hFF : duty_sum[7:0];
      else if (arrow_down) duty <= duty_diff[8] ? 8'h00 : duty_diff[7:0];
    end
  end

endmodule
